// File: rtl/mips_int_pkg.sv
// Shared types and helpers for the MIPS interrupt controller.
package mips_int_pkg;

   localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_0010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_SAFE,
      ST_ENTER,
      ST_HANDLER,
      ST_RETURN
   } int_state_e;

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic logic [4:0] lowest_set(input logic [31:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/int_edge_sync.sv
// Per-bit two-flop synchronizer with rising-edge detection.
module int_edge_sync
   import mips_int_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] rise_c
);

   logic [W-1:0] sync1;
   logic [W-1:0] sync2;
   logic [W-1:0] prev;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= d;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rise_c = sync2 & ~prev;

endmodule

// File: rtl/mips_int_ctrl.sv
// Interrupt capture, safe-point entry and ERET return sequencing for the
// pipelined MIPS core.
module mips_int_ctrl
   import mips_int_pkg::*;
#(
   parameter int unsigned NUM_IRQ      = 4,
   parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
   parameter int unsigned CAUSE_W      = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   input  logic               pipe_stall,
   input  logic               commit_valid,
   input  logic [31:0]        commit_pc,
   input  logic               commit_is_branch,
   input  logic               commit_eret,
   output logic               flush,
   output logic               redirect_en,
   output logic [31:0]        redirect_pc,
   output logic [31:0]        epc,
   output logic [CAUSE_W-1:0] cause,
   output logic               in_handler,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] mask
);

   int_state_e         state;
   logic               progress;
   logic [NUM_IRQ-1:0] rise_c;
   logic [NUM_IRQ-1:0] clr_c;
   logic [CAUSE_W-1:0] sel_c;
   logic               eligible_c;
   logic               safe_c;
   logic               ret_c;

   int_edge_sync #(.W(NUM_IRQ)) u_edge_sync (
      .clk    (clk),
      .rst    (rst),
      .d      (irq_in),
      .rise_c (rise_c)
   );

   assign eligible_c = |(pending & mask);
   assign safe_c     = commit_valid & ~pipe_stall & ~commit_is_branch;
   assign ret_c      = commit_valid & commit_eret & ~pipe_stall;
   assign sel_c      = CAUSE_W'(lowest_set(32'(pending & mask)));

   // Pending bit consumed by the entry taken this cycle.
   always_comb begin
      clr_c = '0;
      if (state == ST_WAIT_SAFE && eligible_c && safe_c) begin
         clr_c = NUM_IRQ'(1) << sel_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_IDLE;
         progress    <= 1'b1;
         flush       <= 1'b0;
         redirect_en <= 1'b0;
         redirect_pc <= '0;
         epc         <= '0;
         cause       <= '0;
         in_handler  <= 1'b0;
         pending     <= '0;
         mask        <= '1;
      end else begin
         flush       <= 1'b0;
         redirect_en <= 1'b0;
         // A new edge wins over the clear of the same bit.
         pending     <= (pending & ~clr_c) | rise_c;
         if (mask_we) mask <= mask_wdata;

         case (state)
            ST_IDLE: begin
               if (eligible_c && progress) state <= ST_WAIT_SAFE;
               if (commit_valid && !pipe_stall) progress <= 1'b1;
            end
            ST_WAIT_SAFE: begin
               if (!eligible_c) begin
                  state <= ST_IDLE;
               end else if (safe_c) begin
                  state       <= ST_ENTER;
                  epc         <= commit_pc;
                  cause       <= sel_c;
                  flush       <= 1'b1;
                  redirect_en <= 1'b1;
                  redirect_pc <= HANDLER_ADDR;
               end
            end
            ST_ENTER: begin
               state      <= ST_HANDLER;
               in_handler <= 1'b1;
            end
            ST_HANDLER: begin
               if (ret_c) begin
                  state       <= ST_RETURN;
                  in_handler  <= 1'b0;
                  flush       <= 1'b1;
                  redirect_en <= 1'b1;
                  redirect_pc <= epc;
               end
            end
            ST_RETURN: begin
               // Re-entry waits until the instruction at epc has committed.
               progress <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_int_ctrl.sv
// Scoreboard bench for mips_int_ctrl: directed scenarios plus random traffic
// checked against a behavioural model.
module tb_mips_int_ctrl;

   localparam logic [31:0] HADDR = 32'h0000_0010;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  irq_in;
   logic        mask_we;
   logic [3:0]  mask_wdata;
   logic        pipe_stall;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic        commit_is_branch;
   logic        commit_eret;
   logic        flush;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic [31:0] epc;
   logic [1:0]  cause;
   logic        in_handler;
   logic [3:0]  pending;
   logic [3:0]  mask;

   mips_int_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .irq_in           (irq_in),
      .mask_we          (mask_we),
      .mask_wdata       (mask_wdata),
      .pipe_stall       (pipe_stall),
      .commit_valid     (commit_valid),
      .commit_pc        (commit_pc),
      .commit_is_branch (commit_is_branch),
      .commit_eret      (commit_eret),
      .flush            (flush),
      .redirect_en      (redirect_en),
      .redirect_pc      (redirect_pc),
      .epc              (epc),
      .cause            (cause),
      .in_handler       (in_handler),
      .pending          (pending),
      .mask             (mask)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct {
      int          at;
      logic [31:0] rpc;
      logic [31:0] epc;
      logic [1:0]  cause;
   } ev_t;
   ev_t sb[$];

   localparam int M_IDLE = 0, M_WAIT = 1, M_ENTER = 2, M_HAND = 3, M_RET = 4;
   int          m_mode;
   logic [3:0]  m_pend, m_mask, m_en, m_rise, m_take;
   logic [3:0]  smp1, smp2, smp3;   // irq_in sampled 1, 2, 3 edges ago
   logic        m_prog, m_inh, m_found;
   logic [31:0] m_epc;
   logic [1:0]  m_cause, m_low;
   ev_t         m_ev;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst) begin
         m_mode = M_IDLE; m_pend = 4'b0; m_mask = 4'b1111;
         smp1 = 4'b0; smp2 = 4'b0; smp3 = 4'b0;
         m_prog = 1'b1; m_inh = 1'b0; m_epc = 32'h0; m_cause = 2'd0;
      end else begin
         m_rise = smp2 & ~smp3;
         smp3 = smp2; smp2 = smp1; smp1 = irq_in;
         m_en = m_pend & m_mask;
         m_take = 4'b0;
         m_found = 1'b0; m_low = 2'd0;
         for (int i = 0; i < 4; i++) begin
            if (m_en[i] && !m_found) begin m_low = 2'(i); m_found = 1'b1; end
         end
         case (m_mode)
            M_IDLE: begin
               if (m_en != 4'b0 && m_prog) m_mode = M_WAIT;
               if (commit_valid && !pipe_stall) m_prog = 1'b1;
            end
            M_WAIT: begin
               if (m_en == 4'b0) m_mode = M_IDLE;
               else if (commit_valid && !pipe_stall && !commit_is_branch) begin
                  m_epc = commit_pc; m_cause = m_low; m_take[m_low] = 1'b1;
                  m_ev.at = cyc; m_ev.rpc = HADDR; m_ev.epc = commit_pc; m_ev.cause = m_low;
                  sb.push_back(m_ev);
                  m_mode = M_ENTER;
               end
            end
            M_ENTER: begin m_mode = M_HAND; m_inh = 1'b1; end
            M_HAND: begin
               if (commit_valid && commit_eret && !pipe_stall) begin
                  m_ev.at = cyc; m_ev.rpc = m_epc; m_ev.epc = m_epc; m_ev.cause = m_cause;
                  sb.push_back(m_ev);
                  m_mode = M_RET; m_inh = 1'b0;
               end
            end
            default: begin m_prog = 1'b0; m_mode = M_IDLE; end
         endcase
         m_pend = (m_pend & ~m_take) | m_rise;
         if (mask_we) m_mask = mask_wdata;
      end
   end

   // ---------------- monitor ----------------
   ev_t mon_ev;
   bit  exp_red;
   always @(negedge clk) begin
      if (mon_en) begin
         exp_red = (sb.size() > 0) && (sb[0].at == cyc);
         chk("mon_redirect_en", 32'(redirect_en), 32'(exp_red));
         chk("mon_flush", 32'(flush), 32'(exp_red));
         if (exp_red) begin
            mon_ev = sb.pop_front();
            chk("mon_redirect_pc", redirect_pc, mon_ev.rpc);
            chk("mon_ev_epc", epc, mon_ev.epc);
            chk("mon_ev_cause", 32'(cause), 32'(mon_ev.cause));
         end else if (sb.size() > 0 && sb[0].at < cyc) begin
            mon_ev = sb.pop_front();
            chk("mon_missed_redirect", 32'(0), 32'(1));
         end
         chk("mon_pending", 32'(pending), 32'(m_pend));
         chk("mon_mask", 32'(mask), 32'(m_mask));
         chk("mon_in_handler", 32'(in_handler), 32'(m_inh));
         chk("mon_epc", epc, m_epc);
         chk("mon_cause", 32'(cause), 32'(m_cause));
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_redirect(input int budget);
      int n = 0;
      while (!redirect_en && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_redirect_timeout", 32'(redirect_en), 32'(1));
   endtask

   // Called on the ENTER cycle: step into HANDLER, then commit an ERET.
   task automatic do_eret();
      @(negedge clk);
      commit_eret = 1'b1;
      @(negedge clk);
      chk("eret_redirect", 32'(redirect_en), 32'(1));
      chk("eret_in_handler", 32'(in_handler), 32'(0));
      commit_eret = 1'b0;
   endtask

   initial begin
      rst = 1'b0; irq_in = 4'b1111; mask_we = 1'b0; mask_wdata = 4'b0;
      pipe_stall = 1'b0; commit_valid = 1'b0; commit_pc = 32'h0;
      commit_is_branch = 1'b0; commit_eret = 1'b0;

      // Reset with all lines high; pending appears only 3 edges after release.
      repeat (5) @(negedge clk);
      mon_en = 1'b1;
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_mask", 32'(mask), 32'hf);
      chk("rst_flush", 32'(flush), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("rel1_pending", 32'(pending), 32'h0);
      @(negedge clk);
      chk("rel2_pending", 32'(pending), 32'h0);
      @(negedge clk);
      chk("rel3_pending", 32'(pending), 32'hf);
      irq_in = 4'b0; rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Single interrupt on source 2, pipeline safe every cycle.
      commit_valid = 1'b1; commit_pc = 32'h40;
      irq_in = 4'b0100;
      @(negedge clk);
      irq_in = 4'b0;
      repeat (4) @(negedge clk);
      chk("single_flush", 32'(flush), 32'h1);
      chk("single_redirect_pc", redirect_pc, HADDR);
      chk("single_epc", epc, 32'h40);
      chk("single_cause", 32'(cause), 32'h2);
      @(negedge clk);
      chk("single_flush_off", 32'(flush), 32'h0);
      chk("single_in_handler", 32'(in_handler), 32'h1);
      chk("single_pending", 32'(pending), 32'h0);
      commit_eret = 1'b1;
      @(negedge clk);
      chk("single_ret_pc", redirect_pc, 32'h40);
      commit_eret = 1'b0;

      // Two sources together: lowest index first, the other waits.
      commit_pc = 32'h100;
      irq_in = 4'b1010;
      @(negedge clk);
      irq_in = 4'b0;
      wait_redirect(20);
      chk("prio_cause_first", 32'(cause), 32'h1);
      chk("prio_epc_first", epc, 32'h100);
      repeat (3) begin
         @(negedge clk);
         chk("prio_pending3", 32'(pending[3]), 32'h1);
         chk("prio_in_handler", 32'(in_handler), 32'h1);
      end
      commit_eret = 1'b1; commit_pc = 32'h200;
      @(negedge clk);
      chk("prio_ret_pc", redirect_pc, 32'h100);
      commit_eret = 1'b0; commit_pc = 32'h104;
      @(negedge clk);
      wait_redirect(20);
      chk("prio_cause_second", 32'(cause), 32'h3);
      chk("prio_epc_second", epc, 32'h104);
      do_eret();

      // Branch then stalled delay slot: entry only on the first clean slot.
      commit_is_branch = 1'b1; commit_pc = 32'h80; irq_in = 4'b0001;
      @(negedge clk);
      irq_in = 4'b0;
      repeat (6) begin
         @(negedge clk);
         chk("branch_no_flush", 32'(flush), 32'h0);
      end
      commit_is_branch = 1'b0; commit_pc = 32'h84; pipe_stall = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("stall_no_flush", 32'(flush), 32'h0);
      end
      pipe_stall = 1'b0;
      @(negedge clk);
      chk("slot_flush", 32'(flush), 32'h1);
      chk("slot_epc", epc, 32'h84);
      chk("slot_cause", 32'(cause), 32'h0);
      do_eret();

      // Masked source stays pending until re-enabled.
      mask_we = 1'b1; mask_wdata = 4'b1110;
      @(negedge clk);
      mask_we = 1'b0; irq_in = 4'b0001;
      @(negedge clk);
      irq_in = 4'b0;
      repeat (20) begin
         @(negedge clk);
         chk("masked_no_redirect", 32'(redirect_en), 32'h0);
      end
      chk("masked_pending0", 32'(pending[0]), 32'h1);
      chk("masked_mask", 32'(mask), 32'he);
      mask_we = 1'b1; mask_wdata = 4'b1111;
      @(negedge clk);
      mask_we = 1'b0;
      wait_redirect(10);
      chk("unmask_cause", 32'(cause), 32'h0);
      do_eret();

      // Reset while in the handler.
      commit_pc = 32'h300; irq_in = 4'b0010;
      @(negedge clk);
      irq_in = 4'b0;
      wait_redirect(20);
      chk("mid_epc", epc, 32'h300);
      @(negedge clk);
      chk("mid_in_handler", 32'(in_handler), 32'h1);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_in_handler", 32'(in_handler), 32'h0);
      chk("mid_rst_epc", epc, 32'h0);
      chk("mid_rst_pending", 32'(pending), 32'h0);
      chk("mid_rst_flush", 32'(flush), 32'h0);
      rst = 1'b1;

      // Random traffic, checked by the monitor against the model.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         irq_in = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
         commit_valid = ($urandom % 4) != 0;
         pipe_stall = ($urandom % 5) == 0;
         commit_is_branch = ($urandom % 6) == 0;
         commit_eret = in_handler ? (($urandom % 4) == 0) : (($urandom % 20) == 0);
         commit_pc = {$urandom, 2'b00} & 32'h0000_fffc;
         mask_we = ($urandom % 40) == 0;
         mask_wdata = 4'($urandom);
         rst = ($urandom % 400) != 0;
      end

      // Quiesce so no further redirect can be generated, then drain.
      @(negedge clk);
      rst = 1'b1; commit_valid = 1'b0; commit_eret = 1'b0; irq_in = 4'b0; mask_we = 1'b0;
      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'h0);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
